// File: rtl/fft_pkg.sv
// fft_pkg: shared butterfly widths and the pipeline latency used for stage-buffer delay matching.
package fft_pkg;
   localparam int DATA_W = 16;
   localparam int TW_W = 16;
   localparam int TW_FRAC_DEF = 13;
   localparam int MULT_LAT_DEF = 8;
   function automatic int latency(input int mult_lat);
      return mult_lat + 4;
   endfunction
endpackage

// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: sample-pair handshake bus of the butterfly; master drives samples, slave is the butterfly.
interface butterfly_pipe_if
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int TW_WIDTH = TW_W
);
   logic in_valid, in_ready, mode, scale, out_valid, out_ready, out_ovf, ovf_sticky, ovf_clr;
   logic signed [DATA_WIDTH-1:0] xp_real, xp_imag, xq_real, xq_imag;
   logic signed [DATA_WIDTH-1:0] yp_real, yp_imag, yq_real, yq_imag;
   logic signed [TW_WIDTH-1:0] factor_real, factor_imag;
   modport master (
      output in_valid, mode, scale, xp_real, xp_imag, xq_real, xq_imag, factor_real, factor_imag,
      output out_ready, ovf_clr,
      input in_ready, out_valid, yp_real, yp_imag, yq_real, yq_imag, out_ovf, ovf_sticky
   );
   modport slave (
      input in_valid, mode, scale, xp_real, xp_imag, xq_real, xq_imag, factor_real, factor_imag,
      input out_ready, ovf_clr,
      output in_ready, out_valid, yp_real, yp_imag, yq_real, yq_imag, out_ovf, ovf_sticky
   );
endinterface

// File: rtl/cmult_pipe.sv
// cmult_pipe: complex multiplier, ML registered product stages plus one re/im combine register, all held by en.
module cmult_pipe #(
   parameter int AW = 17,
   parameter int BW = 16,
   parameter int ML = 8
) (
   input  logic                     clk_data,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic signed [AW-1:0]     a_re,
   input  logic signed [AW-1:0]     a_im,
   input  logic signed [BW-1:0]     b_re,
   input  logic signed [BW-1:0]     b_im,
   output logic signed [AW+BW:0]    p_re,
   output logic signed [AW+BW:0]    p_im
);
   localparam int PW = AW + BW;
   logic signed [PW-1:0] ac [ML];
   logic signed [PW-1:0] bd [ML];
   logic signed [PW-1:0] ad [ML];
   logic signed [PW-1:0] bc [ML];
   always_ff @(posedge clk_data or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < ML; i++) begin
            ac[i] <= '0;
            bd[i] <= '0;
            ad[i] <= '0;
            bc[i] <= '0;
         end
         p_re <= '0;
         p_im <= '0;
      end else if (en) begin
         ac[0] <= PW'(a_re) * PW'(b_re);
         bd[0] <= PW'(a_im) * PW'(b_im);
         ad[0] <= PW'(a_re) * PW'(b_im);
         bc[0] <= PW'(a_im) * PW'(b_re);
         for (int i = 1; i < ML; i++) begin
            ac[i] <= ac[i-1];
            bd[i] <= bd[i-1];
            ad[i] <= ad[i-1];
            bc[i] <= bc[i-1];
         end
         p_re <= (PW+1)'(ac[ML-1]) - (PW+1)'(bd[ML-1]);
         p_im <= (PW+1)'(ad[ML-1]) + (PW+1)'(bc[ML-1]);
      end
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: pipelined radix-2 complex butterfly (DIT/DIF) with rounding, optional /2,
// saturation and a single global stall so every stage holds together under backpressure.
module butterfly_pipe
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int TW_WIDTH = TW_W,
   parameter int TW_FRAC = TW_FRAC_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF
) (
   input logic clk_data,
   input logic rst_n,
   butterfly_pipe_if.slave bus
);
   localparam int AW = DATA_WIDTH + 1;
   localparam int CW = AW + TW_WIDTH + 1;
   localparam int ACC = DATA_WIDTH + TW_WIDTH + 3;
   localparam int SW = 2 * AW + 3;
   localparam logic signed [ACC-1:0] Y_MAX = ACC'((64'sd1 <<< (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC-1:0] Y_MIN = -Y_MAX - 1;
   logic pipe_en, v1, mode1, scale1, vd, moded, scaled, v3, scale3, v4;
   logic out_valid, out_ovf, ovf_sticky;
   logic signed [AW-1:0] xp_re, xp_im, xq_re, xq_im, a_re, a_im, p_re, p_im, pd_re, pd_im;
   logic signed [TW_WIDTH-1:0] w_re, w_im;
   logic signed [CW-1:0] m_re, m_im;
   logic signed [ACC-1:0] al_re, al_im;
   logic [SW-1:0] side [MULT_LAT+1];
   logic signed [ACC-1:0] sum [4];
   logic signed [ACC-1:0] s3 [4];
   logic signed [ACC-1:0] s4 [4];
   logic [3:0] clip;
   logic signed [DATA_WIDTH-1:0] sat [4];
   logic signed [DATA_WIDTH-1:0] y [4];
   function automatic logic signed [ACC-1:0] rnd(input logic signed [ACC-1:0] x, input logic sc);
      return (x + (ACC'(1) <<< (TW_FRAC - 1 + int'(sc)))) >>> (TW_FRAC + int'(sc));
   endfunction
   assign pipe_en = !(out_valid && !bus.out_ready);
   assign bus.in_ready = pipe_en;
   assign xp_re = AW'(bus.xp_real);
   assign xp_im = AW'(bus.xp_imag);
   assign xq_re = AW'(bus.xq_real);
   assign xq_im = AW'(bus.xq_imag);
   // DIF forms xp-xq for the multiplier and xp+xq for the bypass right at the input register
   always_ff @(posedge clk_data or negedge rst_n)
      if (!rst_n) begin
         {v1, mode1, scale1} <= '0;
         {a_re, a_im, p_re, p_im} <= '0;
         {w_re, w_im} <= '0;
      end else if (pipe_en) begin
         v1 <= bus.in_valid;
         mode1 <= bus.mode;
         scale1 <= bus.scale;
         a_re <= bus.mode ? xp_re - xq_re : xq_re;
         a_im <= bus.mode ? xp_im - xq_im : xq_im;
         p_re <= bus.mode ? xp_re + xq_re : xp_re;
         p_im <= bus.mode ? xp_im + xq_im : xp_im;
         w_re <= bus.factor_real;
         w_im <= bus.factor_imag;
      end
   cmult_pipe #(.AW(AW), .BW(TW_WIDTH), .ML(MULT_LAT)) u_cmult (
      .clk_data(clk_data), .rst_n(rst_n), .en(pipe_en),
      .a_re(a_re), .a_im(a_im), .b_re(w_re), .b_im(w_im),
      .p_re(m_re), .p_im(m_im)
   );
   always_ff @(posedge clk_data or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i <= MULT_LAT; i++) side[i] <= '0;
      end else if (pipe_en) begin
         side[0] <= {v1, mode1, scale1, p_re, p_im};
         for (int i = 1; i <= MULT_LAT; i++) side[i] <= side[i-1];
      end
   assign {vd, moded, scaled, pd_re, pd_im} = side[MULT_LAT];
   assign al_re = ACC'(pd_re) <<< TW_FRAC;
   assign al_im = ACC'(pd_im) <<< TW_FRAC;
   assign sum[0] = moded ? al_re : al_re + ACC'(m_re);
   assign sum[1] = moded ? al_im : al_im + ACC'(m_im);
   assign sum[2] = moded ? ACC'(m_re) : al_re - ACC'(m_re);
   assign sum[3] = moded ? ACC'(m_im) : al_im - ACC'(m_im);
   always_ff @(posedge clk_data or negedge rst_n)
      if (!rst_n) begin
         {v3, scale3, v4} <= '0;
         for (int i = 0; i < 4; i++) begin
            s3[i] <= '0;
            s4[i] <= '0;
         end
      end else if (pipe_en) begin
         v3 <= vd;
         scale3 <= scaled;
         v4 <= v3;
         for (int i = 0; i < 4; i++) begin
            s3[i] <= sum[i];
            s4[i] <= rnd(s3[i], scale3);
         end
      end
   always_comb
      for (int i = 0; i < 4; i++) begin
         clip[i] = s4[i] > Y_MAX || s4[i] < Y_MIN;
         sat[i] = s4[i] > Y_MAX ? Y_MAX[DATA_WIDTH-1:0] :
                  s4[i] < Y_MIN ? Y_MIN[DATA_WIDTH-1:0] : s4[i][DATA_WIDTH-1:0];
      end
   always_ff @(posedge clk_data or negedge rst_n)
      if (!rst_n) begin
         {out_valid, out_ovf} <= '0;
         for (int i = 0; i < 4; i++) y[i] <= '0;
      end else if (pipe_en) begin
         out_valid <= v4;
         out_ovf <= v4 && |clip;
         for (int i = 0; i < 4; i++) y[i] <= sat[i];
      end
   always_ff @(posedge clk_data or negedge rst_n)
      if (!rst_n) ovf_sticky <= 1'b0;
      else if (bus.ovf_clr) ovf_sticky <= 1'b0;
      else if (out_valid && bus.out_ready && out_ovf) ovf_sticky <= 1'b1;
   assign bus.out_valid = out_valid;
   assign bus.out_ovf = out_ovf;
   assign bus.ovf_sticky = ovf_sticky;
   assign bus.yp_real = y[0];
   assign bus.yp_imag = y[1];
   assign bus.yq_real = y[2];
   assign bus.yq_imag = y[3];
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed butterfly cases plus randomized backpressure streams against an arithmetic model.
module tb_butterfly_pipe;
   typedef struct { longint pr, pi, qr, qi; bit ovf; } res_t;
   logic clk_data = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   res_t q[$];
   butterfly_pipe_if #(.DATA_WIDTH(16), .TW_WIDTH(16)) b ();
   butterfly_pipe #(.DATA_WIDTH(16), .TW_WIDTH(16), .TW_FRAC(13), .MULT_LAT(8)) dut (
      .clk_data(clk_data), .rst_n(rst_n), .bus(b.slave)
   );
   always #5 clk_data = ~clk_data;
   function automatic longint fit(longint v, bit sc, output bit ovf);
      longint r = (v + (64'sd1 << (12 + sc))) >>> (13 + sc);
      ovf = r > 32767 || r < -32768;
      return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
   endfunction
   function automatic res_t model(bit md, bit sc, longint xpr, longint xpi, longint xqr, longint xqi,
                                  longint wr, longint wi);
      longint y[4];
      bit o[4];
      res_t r;
      if (md) begin
         y[0] = (xpr + xqr) * 8192;
         y[1] = (xpi + xqi) * 8192;
         y[2] = (xpr - xqr) * wr - (xpi - xqi) * wi;
         y[3] = (xpr - xqr) * wi + (xpi - xqi) * wr;
      end else begin
         y[0] = xpr * 8192 + (xqr * wr - xqi * wi);
         y[1] = xpi * 8192 + (xqr * wi + xqi * wr);
         y[2] = xpr * 8192 - (xqr * wr - xqi * wi);
         y[3] = xpi * 8192 - (xqr * wi + xqi * wr);
      end
      r.pr = fit(y[0], sc, o[0]);
      r.pi = fit(y[1], sc, o[1]);
      r.qr = fit(y[2], sc, o[2]);
      r.qi = fit(y[3], sc, o[3]);
      r.ovf = o[0] | o[1] | o[2] | o[3];
      return r;
   endfunction
   task automatic chk(string tag, longint obs, longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic chk_out(string tag, res_t e);
      chk({tag, "_ypr"}, b.yp_real, e.pr);
      chk({tag, "_ypi"}, b.yp_imag, e.pi);
      chk({tag, "_yqr"}, b.yq_real, e.qr);
      chk({tag, "_yqi"}, b.yq_imag, e.qi);
      chk({tag, "_ovf"}, longint'(b.out_ovf), longint'(e.ovf));
   endtask
   task automatic directed(string tag, bit md, bit sc, int xpr, int xpi, int xqr, int xqi,
                           int wr, int wi, res_t e);
      int n = 0;
      b.mode = md;
      b.scale = sc;
      b.xp_real = 16'(xpr);
      b.xp_imag = 16'(xpi);
      b.xq_real = 16'(xqr);
      b.xq_imag = 16'(xqi);
      b.factor_real = 16'(wr);
      b.factor_imag = 16'(wi);
      b.out_ready = 1'b1;
      b.in_valid = 1'b1;
      @(posedge clk_data);
      #1 b.in_valid = 1'b0;
      while (!b.out_valid && n < 40) begin
         @(posedge clk_data);
         #1 n++;
      end
      chk({tag, "_lat"}, n, 12);
      chk_out(tag, e);
      @(posedge clk_data);
      #1;
   endtask
   task automatic stream(int n, int abort_at);
      int sent = 0;
      int got = 0;
      int burst = 0;
      res_t e;
      for (int cyc = 0; cyc < 3000 && got < n && (abort_at == 0 || cyc < abort_at); cyc++) begin
         b.in_valid = sent < n && $urandom_range(3) != 0;
         b.mode = 1'($urandom);
         b.scale = 1'($urandom);
         b.xp_real = 16'($urandom);
         b.xp_imag = 16'($urandom);
         b.xq_real = 16'($urandom);
         b.xq_imag = 16'($urandom);
         b.factor_real = 16'(int'($urandom_range(16384)) - 8192);
         b.factor_imag = 16'(int'($urandom_range(16384)) - 8192);
         if (burst > 0) begin
            burst--;
            b.out_ready = 1'b0;
         end else if ($urandom_range(5) == 0) begin
            burst = 4;
            b.out_ready = 1'b0;
         end else b.out_ready = 1'b1;
         @(negedge clk_data);
         if (b.out_valid && b.out_ready) begin
            if (q.size() == 0) chk("rnd_spurious", 1, 0);
            else begin
               e = q.pop_front();
               chk_out("rnd", e);
            end
            got++;
         end
         if (b.in_valid && b.in_ready) begin
            q.push_back(model(b.mode, b.scale, b.xp_real, b.xp_imag, b.xq_real, b.xq_imag,
                              b.factor_real, b.factor_imag));
            sent++;
         end
         @(posedge clk_data);
         #1;
      end
      if (abort_at == 0) chk("rnd_count", got, n);
   endtask
   initial begin
      int n;
      {b.in_valid, b.mode, b.scale, b.out_ready, b.ovf_clr} = '0;
      {b.xp_real, b.xp_imag, b.xq_real, b.xq_imag, b.factor_real, b.factor_imag} = '0;
      repeat (3) @(posedge clk_data);
      #1;
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_out_ovf", b.out_ovf, 0);
      chk("rst_sticky", b.ovf_sticky, 0);
      chk("rst_ypr", b.yp_real, 0);
      chk("rst_yqi", b.yq_imag, 0);
      rst_n = 1'b1;
      @(posedge clk_data);
      #1 chk("idle_in_ready", b.in_ready, 1);
      directed("dit_unity", 0, 0, 100, 0, 50, 0, 8192, 0, '{150, 0, 50, 0, 0});
      directed("dit_negj", 0, 0, 0, 0, 100, 0, 0, -8192, '{0, -100, 0, 100, 0});
      directed("dif_j", 1, 0, 10, 0, 4, 0, 0, 8192, '{14, 0, 0, 6, 0});
      chk("sticky_clean", b.ovf_sticky, 0);
      directed("sat", 0, 0, 32767, 0, 32767, 0, 8192, 0, '{32767, 0, 0, 0, 1});
      chk("sticky_set", b.ovf_sticky, 1);
      @(posedge clk_data);
      #1 chk("sticky_hold", b.ovf_sticky, 1);
      b.ovf_clr = 1'b1;
      @(posedge clk_data);
      #1 b.ovf_clr = 1'b0;
      chk("sticky_clr", b.ovf_sticky, 0);
      directed("scale_pos", 0, 1, 3, 0, 0, 0, 8192, 0, '{2, 0, 2, 0, 0});
      directed("scale_neg", 0, 1, -3, 0, 0, 0, 8192, 0, '{-1, 0, -1, 0, 0});
      stream(32, 0);
      stream(32, 30);
      b.in_valid = 1'b0;
      b.out_ready = 1'b0;
      n = 0;
      while (!b.out_valid && n < 20) begin
         @(posedge clk_data);
         #1 n++;
      end
      chk("pre_rst_valid", b.out_valid, 1);
      rst_n = 1'b0;
      #1 chk("rst_async_valid", b.out_valid, 0);
      q.delete();
      @(posedge clk_data);
      #1 rst_n = 1'b1;
      @(posedge clk_data);
      #1 chk("post_rst_valid", b.out_valid, 0);
      directed("post_rst", 0, 0, 100, 0, 50, 0, 8192, 0, '{150, 0, 50, 0, 0});
      stream(32, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
